onehot_port_encoder: RTL and testbench

- Inverse-direction companion to the router's fixed-priority one-hot selector.
- Accepts a stream of NUM_PORT-wide one-hot port grants and emits the binary port index the crossbar and output-port muxes consume.
- Buffers through a 2-entry skid buffer with valid/ready on both sides.
- Flags non-one-hot grants. Sits between the port allocator and the crossbar control register stage.

---
 rtl/onehot_port_encoder.sv | 152 +++++++++++++++
 tb/tb_onehot_port_encoder.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/onehot_port_encoder.sv
// One-hot grant to binary port index encoder behind a 2-entry skid buffer.
// Optional per-port grant counters are enabled by defining PORT_GRANT_CNT_EN.
`ifndef NUM_PORT
`define NUM_PORT 5
`endif

module onehot_port_encoder #(
    parameter int NUM_PORT = `NUM_PORT,
    parameter int IDX_W    = 3,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [NUM_PORT-1:0] in_onehot,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [IDX_W-1:0]    out_idx,
    output logic                out_illegal,
    output logic                err_sticky,
    input  logic                err_clr,
    input  logic [IDX_W-1:0]    cnt_sel,
    output logic [CNT_W-1:0]    cnt_out
);

    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_e;

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  out_idx_q, skid_idx_q, enc_idx;
    logic              out_ill_q, skid_ill_q, err_q, err_d;
    logic              enc_legal, push, pop;
    logic              load_out_in, load_skid, load_out_skid;

    // Highest set bit wins on multi-hot vectors; zero encodes to 0.
    always_comb begin
        enc_idx = '0;
        for (int i = 0; i < NUM_PORT; i++)
            if (in_onehot[i]) enc_idx = IDX_W'(i);
    end

    assign enc_legal = (in_onehot != '0) &&
                       ((in_onehot & (in_onehot - NUM_PORT'(1))) == '0);

    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= EMPTY;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            EMPTY:   if (push) state_d = ONE;
            ONE: begin
                if (push && !pop)      state_d = FULL;
                else if (!push && pop) state_d = EMPTY;
            end
            FULL:    if (pop) state_d = ONE;
            default: state_d = EMPTY;
        endcase
    end

    // Ready is a pure function of occupancy so no out_ready -> in_ready path exists.
    always_comb begin
        in_ready  = 1'b1;
        out_valid = 1'b0;
        unique case (state_q)
            EMPTY:   begin in_ready = 1'b1; out_valid = 1'b0; end
            ONE:     begin in_ready = 1'b1; out_valid = 1'b1; end
            FULL:    begin in_ready = 1'b0; out_valid = 1'b1; end
            default: begin in_ready = 1'b1; out_valid = 1'b0; end
        endcase
    end

    assign load_out_in   = push && ((state_q == EMPTY) || ((state_q == ONE) && pop));
    assign load_skid     = push && (state_q == ONE) && !pop;
    assign load_out_skid = pop && (state_q == FULL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_idx_q  <= '0;
            out_ill_q  <= 1'b0;
            skid_idx_q <= '0;
            skid_ill_q <= 1'b0;
        end else begin
            if (load_out_in) begin
                out_idx_q <= enc_idx;
                out_ill_q <= !enc_legal;
            end else if (load_out_skid) begin
                out_idx_q <= skid_idx_q;
                out_ill_q <= skid_ill_q;
            end
            if (load_skid) begin
                skid_idx_q <= enc_idx;
                skid_ill_q <= !enc_legal;
            end
        end
    end

    assign out_idx     = out_idx_q;
    assign out_illegal = out_ill_q;

    // Set has priority over clear when both land in the same cycle.
    always_comb begin
        err_d = err_q;
        if (err_clr)                err_d = 1'b0;
        if (push && !enc_legal)     err_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_q <= 1'b0;
        else        err_q <= err_d;
    end

    assign err_sticky = err_q;

`ifdef PORT_GRANT_CNT_EN
    logic [NUM_PORT-1:0][CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0]               cnt_rd, cnt_out_q;

    for (genvar p = 0; p < NUM_PORT; p++) begin : g_cnt
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                cnt_q[p] <= '0;
            else if (push && enc_legal && (enc_idx == IDX_W'(p)) && !(&cnt_q[p]))
                cnt_q[p] <= cnt_q[p] + CNT_W'(1);
        end
    end

    // Out-of-range selects fall through to zero.
    always_comb begin
        cnt_rd = '0;
        for (int p = 0; p < NUM_PORT; p++)
            if (cnt_sel == IDX_W'(p)) cnt_rd = cnt_q[p];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_out_q <= '0;
        else        cnt_out_q <= cnt_rd;
    end

    assign cnt_out = cnt_out_q;
`else
    logic unused_cnt_sel;
    assign unused_cnt_sel = ^cnt_sel;
    assign cnt_out        = '0;
`endif

endmodule

// File: tb/tb_onehot_port_encoder.sv
// Directed bench for onehot_port_encoder: encode, skid handshake, errors, reset, counters.
module tb_onehot_port_encoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [4:0]  in_onehot;
    logic        out_valid, out_ready;
    logic [2:0]  out_idx;
    logic        out_illegal, err_sticky, err_clr;
    logic [2:0]  cnt_sel;
    logic [15:0] cnt_out;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    onehot_port_encoder dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_onehot(in_onehot),
        .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
        .out_illegal(out_illegal), .err_sticky(err_sticky), .err_clr(err_clr),
        .cnt_sel(cnt_sel), .cnt_out(cnt_out)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [4:0] v);
        in_valid  = 1'b1;
        in_onehot = v;
        tick();
        in_valid  = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_onehot = '0;
        out_ready = 1'b0; err_clr = 1'b0; cnt_sel = '0;
        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_idx", out_idx, 0);
        chk("rst_out_illegal", out_illegal, 0);
        chk("rst_err", err_sticky, 0);
        chk("rst_cnt_out", cnt_out, 0);
        chk("rst_in_ready", in_ready, 1);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // Basic encode, one-cycle latency
        out_ready = 1'b1;
        push(5'b00100);
        chk("enc2_valid", out_valid, 1);
        chk("enc2_idx", out_idx, 2);
        chk("enc2_ill", out_illegal, 0);
        tick();
        chk("enc2_drain", out_valid, 0);

        // Fill to FULL with output stalled
        out_ready = 1'b0;
        push(5'b00001);
        chk("one_in_ready", in_ready, 1);
        chk("one_idx", out_idx, 0);
        push(5'b10000);
        chk("full_in_ready", in_ready, 0);
        chk("full_out_valid", out_valid, 1);
        push(5'b00010);
        chk("full_hold_idx", out_idx, 0);
        chk("full_hold_ready", in_ready, 0);
        out_ready = 1'b1;
        tick();
        chk("pop1_idx", out_idx, 4);
        chk("pop1_in_ready", in_ready, 1);
        chk("pop1_valid", out_valid, 1);
        tick();
        chk("pop2_empty", out_valid, 0);

        // Illegal beats and sticky error
        push(5'b01010);
        chk("multi_idx", out_idx, 3);
        chk("multi_ill", out_illegal, 1);
        chk("multi_err", err_sticky, 1);
        push(5'b00000);
        chk("zero_idx", out_idx, 0);
        chk("zero_ill", out_illegal, 1);
        tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("err_clr", err_sticky, 0);
        err_clr = 1'b1;
        push(5'b00011);
        err_clr = 1'b0;
        chk("set_wins_err", err_sticky, 1);
        chk("set_wins_idx", out_idx, 1);
        tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("err_clr2", err_sticky, 0);

        // Simultaneous push and pop in ONE
        out_ready = 1'b0;
        push(5'b01000);
        chk("sim_pre_idx", out_idx, 3);
        out_ready = 1'b1;
        push(5'b00010);
        chk("sim_idx", out_idx, 1);
        chk("sim_ill", out_illegal, 0);
        chk("sim_in_ready", in_ready, 1);
        chk("sim_valid", out_valid, 1);
        tick();
        chk("sim_no_dup", out_valid, 0);

        // Reset while FULL
        out_ready = 1'b0;
        push(5'b00100);
        push(5'b00010);
        chk("prerst_full", in_ready, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_valid", out_valid, 0);
        chk("midrst_ready", in_ready, 1);
        chk("midrst_idx", out_idx, 0);
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        tick();
        chk("postrst_valid", out_valid, 0);
        chk("postrst_ready", in_ready, 1);
        tick();
        chk("postrst_valid2", out_valid, 0);

`ifdef PORT_GRANT_CNT_EN
        push(5'b10000);
        push(5'b10000);
        push(5'b10000);
        push(5'b10001);
        cnt_sel = 3'd4;
        tick();
        chk("cnt_port4", cnt_out, 3);
        cnt_sel = 3'd0;
        tick();
        chk("cnt_port0", cnt_out, 0);
        cnt_sel = 3'd5;
        tick();
        chk("cnt_oob", cnt_out, 0);
`else
        push(5'b10000);
        cnt_sel = 3'd4;
        tick();
        chk("cnt_disabled", cnt_out, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
